countdown_timer: RTL and testbench

//  Loadable N-bit down-counter/timer: the counterpart of the free-running up

---
 rtl/countdown_timer.sv | 109 ++++++++++
 tb/tb_countdown_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable N-bit down-counter/timer. A loaded value is counted down once per
//   clock after start; a one-cycle done pulse marks expiry. With AUTO_RELOAD
//   set, expiry reloads the stored value and keeps running, giving a periodic
//   tick of period reload value.
//
// Parameters
//   N            counter width in bits
//   AUTO_RELOAD  1: reload from stored value on expiry and keep running
//
// Ports
//   clk         in   clock, all state updates on rising edge
//   reset       in   synchronous, active-high reset
//   load        in   load load_value into count and reload register (aborts a run)
//   load_value  in   N-bit value captured when load=1
//   start       in   begin counting (honoured only when idle)
//   pause       in   level: hold count while high
//   count       out  current count, registered
//   busy        out  high while running or held, registered
//   done        out  one-cycle registered pulse on expiry
module countdown_timer #(
  parameter int unsigned N           = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [N-1:0] CountOne = N'(1);

  state_e       state_q;
  logic [N-1:0] reload_q;

  // Priority per edge: reset > load > start > pause > decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count    <= '0;
      reload_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Load aborts any run silently.
        count    <= load_value;
        reload_q <= load_value;
        state_q  <= StIdle;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (count != '0) begin
                // Count is left untouched on the start edge.
                state_q <= pause ? StHold : StRun;
                busy    <= 1'b1;
              end else begin
                // Starting an already-expired timer expires immediately.
                done <= 1'b1;
              end
            end
          end
          StRun: begin
            if (pause) begin
              state_q <= StHold;
            end else if (count == CountOne) begin
              done <= 1'b1;
              if (AUTO_RELOAD) begin
                // Reload instead of showing zero, so the period is reload_q.
                count <= reload_q;
              end else begin
                count   <= '0;
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              count <= count - CountOne;
            end
          end
          StHold: begin
            // Resume only changes state; decrement restarts on the next edge.
            if (!pause) begin
              state_q <= StRun;
            end
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [N-1:0] load_value;
  logic         start;
  logic         pause;

  logic [N-1:0] count0, count1;
  logic         busy0, busy1;
  logic         done0, done1;

  countdown_timer #(.N(N), .AUTO_RELOAD(1'b0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count0),
    .busy       (busy0),
    .done       (done0)
  );

  countdown_timer #(.N(N), .AUTO_RELOAD(1'b1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count1),
    .busy       (busy1),
    .done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] c0;
    logic         b0;
    logic         d0;
    logic [N-1:0] c1;
    logic         b1;
    logic         d1;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a timer is "active" with some remaining time, possibly
  // held; index 0 stops at expiry, index 1 reloads its period.
  int m_rem[2];
  int m_per[2];
  bit m_act[2];
  bit m_held[2];
  bit m_done[2];

  task automatic step(input bit r, input bit l, input int lv, input bit s, input bit p);
    exp_t e;
    @(negedge clk);
    reset      = r;
    load       = l;
    load_value = lv[N-1:0];
    start      = s;
    pause      = p;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (r) begin
        m_rem[i] = 0; m_per[i] = 0; m_act[i] = 1'b0; m_held[i] = 1'b0;
      end else if (l) begin
        m_rem[i] = lv; m_per[i] = lv; m_act[i] = 1'b0; m_held[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (s) begin
          if (m_rem[i] == 0) m_done[i] = 1'b1;
          else begin
            m_act[i]  = 1'b1;
            m_held[i] = p;
          end
        end
      end else if (m_held[i]) begin
        if (!p) m_held[i] = 1'b0;
      end else if (p) begin
        m_held[i] = 1'b1;
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_done[i] = 1'b1;
          if (i == 1) m_rem[i] = m_per[i];
          else m_act[i] = 1'b0;
        end
      end
    end
    e.c0 = m_rem[0][N-1:0]; e.b0 = m_act[0]; e.d0 = m_done[0];
    e.c1 = m_rem[1][N-1:0]; e.b1 = m_act[1]; e.d1 = m_done[1];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit p);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 1'b0, p);
  endtask

  task automatic chk(input string name, input int act, input int req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, req);
    end
  endtask

  // Monitor: every clock edge presents a fresh output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ($isunknown({count0, busy0, done0, count1, busy1, done1})) begin
          miscompares++;
          $display("FAIL x_outputs at vector %0d: got %b, expected known values", vectors,
                   {count0, busy0, done0, count1, busy1, done1});
        end else begin
          chk("count0", int'(count0), int'(e.c0));
          chk("busy0", int'(busy0), int'(e.b0));
          chk("done0", int'(done0), int'(e.d0));
          chk("count1", int'(count1), int'(e.c1));
          chk("busy1", int'(busy1), int'(e.b1));
          chk("done1", int'(done1), int'(e.d1));
        end
      end
    end
  end

  initial begin
    int guard;
    bit p_lvl;
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0;

    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Basic countdown from 5.
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(8, 1'b0);

    // Start with zero loaded: immediate done.
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Pause for three cycles at count 4.
    step(1'b0, 1'b1, 6, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    idle(9, 1'b0);

    // Periodic run, then load mid-run aborts silently.
    step(1'b0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(8, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Reset mid-run clears the reload value too.
    step(1'b0, 1'b1, 15, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(6, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Load+start while running, and start while busy.
    step(1'b0, 1'b1, 7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(5, 1'b0);

    // Maximum period with pause-during-start.
    step(1'b0, 1'b1, 15, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    idle(18, 1'b0);

    // Randomized traffic.
    p_lvl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, p_lvl);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
